reg_bus_ctrl: RTL and testbench
===============================

# reg_bus_ctrl

Sequencer for a bank of 1-bit REG cells that share one write bus and one read bus. It accepts register-transfer commands over a valid/ready handshake and executes each one by driving the per-register output-enable (`out_use`) and load-enable (`in_use`) lines in a fixed cycle sequence. Supported operations are MOV, XOR, CLR and SET. It sits between the instruction decoder and the register bank, and is the only block that drives the register enables.

## Interface
- `N`, 4: number of REG cells on the bus; must satisfy 2 ≤ N ≤ 2**AW.
- `AW`, 2: register address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_op`  in  2  operation: 00 MOV (dst←src), 01 XOR (dst←dst^src), 10 CLR (dst←0), 11 SET (dst←1).
- `cmd_src`  in  AW  source register address.
- `cmd_dst`  in  AW  destination register address.
- `out_use`  out  N  one-hot read enables to the REG cells.
- `in_use`  out  N  one-hot load enables to the REG cells.
- `bus_in`  in  1  shared read bus (OR of the REG outputs); valid in the same cycle as `out_use`.
- `bus_out`  out  1  shared write data to every REG input.
- `busy`  out  1  a command is in flight (state ≠ IDLE).
- `done`  out  1  one-cycle pulse after a command retires.
- `err`  out  1  one-cycle pulse with `done` when src or dst was ≥ N.

## Operation
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`. The op, src, dst and a range-check flag are latched at that edge.
- States: IDLE, RD_A, RD_B, WR.
  - IDLE → RD_A on accept, for MOV and XOR.
  - IDLE → WR on accept, for CLR and SET.
  - RD_A: `out_use[src]`=1; `bus_in` is captured into `a` at the end of the cycle. Next state is WR for MOV, RD_B for XOR.
  - RD_B: `out_use[dst]`=1; `bus_in` is captured into `b`. Next state is WR.
  - WR: `in_use[dst]`=1. `bus_out` is `a` (MOV), `a^b` (XOR), 0 (CLR) or 1 (SET). Next state is IDLE.
- `done` is registered: high in the first cycle after WR, alongside the return to IDLE.
- At most one bit across `in_use|out_use` is high in any cycle. `in_use` and `out_use` are never high in the same cycle.
- Out-of-range address (src or dst ≥ N):
  - The command is still accepted and the state sequence still runs.
  - Any enable bit for an out-of-range address stays 0.
  - `err` pulses together with `done`.
- XOR with src == dst: both reads hit the same cell, so the result written is 0.
- `bus_out` is 0 whenever the state is not WR.
- Reset (asynchronous, at any time, including mid-command):
  - state=IDLE; `in_use`=0, `out_use`=0, `bus_out`=0, `busy`=0, `done`=0, `err`=0; `a`=`b`=0.
  - The in-flight command is discarded with no `done`.
  - `cmd_ready`=1 once reset is deasserted.

## Timing
- Accept edge is t0.
- MOV: RD_A in cycle t0+1, WR in t0+2. The destination REG updates at the end of t0+2. `done` is high in t0+3.
- XOR: RD_A, RD_B, WR in cycles t0+1..t0+3; `done` is high in t0+4.
- CLR/SET: WR in t0+1; `done` is high in t0+2.
- Back-to-back commands: `cmd_ready` is high in the `done` cycle, so the next command can be accepted at the end of that cycle.
- Throughput: one command per 3 (MOV), 4 (XOR) or 2 (CLR/SET) cycles.
- `cmd_op`/`cmd_src`/`cmd_dst` are ignored when no accept occurs. A request may wait indefinitely with `cmd_valid` held high.

## Structure
- Shared package `bitxor_pkg`:
  - op encodings `OP_MOV`, `OP_XOR`, `OP_CLR`, `OP_SET`;
  - state enum `rbc_state_t`.
- Sub-module `reg_sel_dec` (parameters N, AW): address in, enable in → one-hot N-bit out plus an `oor` (out-of-range) flag. Instantiated twice, for the src and dst select.
- FSM, operand latches and output registers live in `reg_bus_ctrl`. All outputs are registered or decoded from registered state only.

## Test plan
- Reset sequencing: reset high for 1 cycle, then a CLR to each of r0..r3, then read each back with MOV → all read 0; `in_use` sequence 0001, 0010, 0100, 1000; `done` pulses 4×.
- SET r1 then MOV r1→r2: `out_use`=0010 at t0+1, `in_use`=0100 and `bus_out`=1 at t0+2 → r2=1; `done` at t0+3.
- XOR:
  - r0=1, r3=1, XOR src=0 dst=3 → r3=0, `done` at t0+4;
  - then XOR src=3 dst=3 → r3 stays 0.
- Back-to-back: `cmd_valid` held high with SET r0, then MOV r0→r1 → second accept in the first command's `done` cycle; r1=1 after 5 total cycles.
- Out-of-range (N=3, AW=2): MOV src=3 dst=0 → no `out_use` bit set, r0 written 0, `done` and `err` both pulse.
- Reset mid-command: assert reset during RD_B of an XOR → all enables 0 immediately, no `done`, destination unchanged, `cmd_ready`=1 after release.

Source files
------------

// File: rtl/bitxor_pkg.sv
// Shared definitions for the REG-bus sequencer: operation encodings, FSM states
// and the write-data rule applied in the WR cycle.
package bitxor_pkg;

    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_XOR = 2'b01,
        OP_CLR = 2'b10,
        OP_SET = 2'b11
    } rbc_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD_A = 2'b01,
        RD_B = 2'b10,
        WR   = 2'b11
    } rbc_state_t;

    function automatic logic wr_value(input rbc_op_t op, input logic a, input logic b);
        case (op)
            OP_MOV:  return a;
            OP_XOR:  return a ^ b;
            OP_CLR:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/reg_sel_dec.sv
// Address decoder for the REG bank: one-hot select gated by an enable, plus a
// range flag for addresses that have no cell behind them.
module reg_sel_dec #(
    parameter int N  = 4,
    parameter int AW = 2
) (
    input  logic [AW-1:0] addr_i,
    input  logic          en_i,
    output logic [N-1:0]  sel_o,
    output logic          oor_o
);

    // An out-of-range address matches no index, so its select stays 0.
    always_comb begin
        oor_o = (int'(addr_i) >= N);
        for (int i = 0; i < N; i++) begin
            sel_o[i] = en_i && (int'(addr_i) == i);
        end
    end

endmodule

// File: rtl/reg_bus_ctrl.sv
// Sequencer that executes MOV/XOR/CLR/SET on a bank of 1-bit REG cells by
// stepping their shared read/write buses through RD_A, RD_B and WR cycles.
module reg_bus_ctrl
    import bitxor_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    output logic [N-1:0]  out_use,
    output logic [N-1:0]  in_use,
    input  logic          bus_in,
    output logic          bus_out,
    output logic          busy,
    output logic          done,
    output logic          err
);

    rbc_state_t    state_q, state_d;
    rbc_op_t       op_q, op_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic          a_q, a_d;
    logic          b_q, b_d;
    logic          oor_q, oor_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          is_idle;
    logic [AW-1:0] src_addr, dst_addr;
    logic [N-1:0]  src_sel, dst_sel;
    logic          src_oor, dst_oor;

    // In IDLE the decoders look at the incoming command so its range flag can be
    // latched at the accept edge; their enables are low there, so no select leaks.
    assign is_idle  = (state_q == IDLE);
    assign src_addr = is_idle ? cmd_src : src_q;
    assign dst_addr = is_idle ? cmd_dst : dst_q;

    reg_sel_dec #(.N(N), .AW(AW)) u_src_dec (
        .addr_i (src_addr),
        .en_i   (state_q == RD_A),
        .sel_o  (src_sel),
        .oor_o  (src_oor)
    );

    reg_sel_dec #(.N(N), .AW(AW)) u_dst_dec (
        .addr_i (dst_addr),
        .en_i   ((state_q == RD_B) || (state_q == WR)),
        .sel_o  (dst_sel),
        .oor_o  (dst_oor)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        a_d     = a_q;
        b_d     = b_q;
        oor_d   = oor_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = rbc_op_t'(cmd_op);
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    oor_d   = src_oor || dst_oor;
                    state_d = (rbc_op_t'(cmd_op) == OP_MOV || rbc_op_t'(cmd_op) == OP_XOR) ? RD_A : WR;
                end
            end
            RD_A: begin
                a_d     = bus_in;
                state_d = (op_q == OP_XOR) ? RD_B : WR;
            end
            RD_B: begin
                b_d     = bus_in;
                state_d = WR;
            end
            WR: begin
                done_d  = 1'b1;
                err_d   = oor_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MOV;
            src_q   <= '0;
            dst_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            oor_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            oor_q   <= oor_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = is_idle;
    assign busy      = !is_idle;
    assign out_use   = src_sel | ((state_q == RD_B) ? dst_sel : '0);
    assign in_use    = (state_q == WR) ? dst_sel : '0;
    assign bus_out   = (state_q == WR) ? wr_value(op_q, a_q, b_q) : 1'b0;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Self-checking bench: two sequencers (N=4 and N=3) each drive a bank of 1-bit
// cells; a plain array model of register contents predicts every cycle.
module tb_reg_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0, cmd_src = 2'd0, cmd_dst = 2'd0;
    logic       sel3 = 1'b0;

    always #5 clk = ~clk;

    logic       ready4, bus_in4, bus_out4, busy4, done4, err4;
    logic [3:0] out_use4, in_use4;
    logic       ready3, bus_in3, bus_out3, busy3, done3, err3;
    logic [2:0] out_use3, in_use3;

    logic [3:0] bank4 = 4'b0;
    logic [2:0] bank3 = 3'b0;

    reg_bus_ctrl #(.N(4), .AW(2)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid & ~sel3), .cmd_ready(ready4),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .out_use(out_use4), .in_use(in_use4), .bus_in(bus_in4), .bus_out(bus_out4),
        .busy(busy4), .done(done4), .err(err4)
    );

    reg_bus_ctrl #(.N(3), .AW(2)) dut3 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid & sel3), .cmd_ready(ready3),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .out_use(out_use3), .in_use(in_use3), .bus_in(bus_in3), .bus_out(bus_out3),
        .busy(busy3), .done(done3), .err(err3)
    );

    // The REG cells themselves: wired-OR read bus, load on in_use.
    assign bus_in4 = |(bank4 & out_use4);
    assign bus_in3 = |(bank3 & out_use3);
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (in_use4[i]) bank4[i] <= bus_out4;
        for (int i = 0; i < 3; i++) if (in_use3[i]) bank3[i] <= bus_out3;
    end

    // {ready, busy, done, err, bus_out, in_use[3:0], out_use[3:0]}
    logic [12:0] obs;
    logic [3:0]  obs_bank;
    assign obs = sel3 ? {ready3, busy3, done3, err3, bus_out3, 1'b0, in_use3, 1'b0, out_use3}
                      : {ready4, busy4, done4, err4, bus_out4, in_use4, out_use4};
    assign obs_bank = sel3 ? {1'b0, bank3} : bank4;

    bit mem [2][4];
    int n_pass = 0;
    int n_total = 0;

    function automatic logic [3:0] onehot(input int a, input int n);
        return (a < n) ? 4'(1 << a) : 4'b0;
    endfunction

    function automatic logic [3:0] model_bank(input int s, input int n);
        logic [3:0] v = 4'b0;
        for (int i = 0; i < n; i++) v[i] = mem[s][i];
        return v;
    endfunction

    // Issue one command, follow it cycle by cycle, then compare the bank.
    task automatic run_cmd(input logic [1:0] op, input int src, input int dst);
        int s, n, lat, waited;
        bit sv, dv, res, bad;
        logic [12:0] exp;
        s   = sel3 ? 1 : 0;
        n   = sel3 ? 3 : 4;
        sv  = (src < n) ? mem[s][src] : 1'b0;
        dv  = (dst < n) ? mem[s][dst] : 1'b0;
        case (op)
            2'd0:    res = sv;
            2'd1:    res = sv ^ dv;
            2'd2:    res = 1'b0;
            default: res = 1'b1;
        endcase
        bad = (src >= n) || (dst >= n);
        lat = (op == 2'd0) ? 2 : (op == 2'd1) ? 3 : 1;

        cmd_op = op; cmd_src = 2'(src); cmd_dst = 2'(dst); cmd_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (obs[12] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_total++;
        if (obs[12] !== 1'b1) $display("FAIL accept_wait: cmd_ready=%b required 1", obs[12]);
        else n_pass++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_src = 2'($urandom); cmd_dst = 2'($urandom);

        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k <= lat)
                exp = {1'b0, 1'b1, 1'b0, 1'b0, (k == lat) ? res : 1'b0,
                       (k == lat) ? onehot(dst, n) : 4'b0,
                       (k < lat) ? onehot((k == 1) ? src : dst, n) : 4'b0};
            else
                exp = {1'b1, 1'b0, 1'b1, bad, 1'b0, 8'b0};
            n_total++;
            if (obs !== exp)
                $display("FAIL cmd op=%0d src=%0d dst=%0d cycle t0+%0d: got %b expected %b",
                         op, src, dst, k, obs, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        if (dst < n) mem[s][dst] = res;
        n_total++;
        if (obs_bank !== model_bank(s, n))
            $display("FAIL bank after op=%0d src=%0d dst=%0d: got %b expected %b",
                     op, src, dst, obs_bank, model_bank(s, n));
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs[11:0] !== 12'b0) $display("FAIL reset_hold: got %b expected 0", obs[11:0]);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (obs !== {1'b1, 12'b0}) $display("FAIL reset_release n4: got %b expected %b", obs, {1'b1, 12'b0});
        else n_pass++;
        sel3 = 1'b1;
        #1;
        n_total++;
        if (obs !== {1'b1, 12'b0}) $display("FAIL reset_release n3: got %b expected %b", obs, {1'b1, 12'b0});
        else n_pass++;
        sel3 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clear_readback();
        for (int i = 0; i < 4; i++) run_cmd(2'd2, $urandom_range(0, 3), i);
        for (int i = 0; i < 4; i++) run_cmd(2'd0, i, i);
    endtask

    task automatic test_set_mov();
        run_cmd(2'd3, 0, 1);
        run_cmd(2'd0, 1, 2);
        n_total++;
        if (bank4[2] !== 1'b1) $display("FAIL set_mov r2: got %b expected 1", bank4[2]);
        else n_pass++;
    endtask

    task automatic test_xor();
        run_cmd(2'd3, 1, 0);
        run_cmd(2'd3, 2, 3);
        run_cmd(2'd1, 0, 3);
        n_total++;
        if (bank4[3] !== 1'b0) $display("FAIL xor r3: got %b expected 0", bank4[3]);
        else n_pass++;
        run_cmd(2'd1, 3, 3);
        run_cmd(2'd3, 0, 2);
        run_cmd(2'd1, 2, 2);
        n_total++;
        if (bank4[2] !== 1'b0) $display("FAIL xor_self r2: got %b expected 0", bank4[2]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp [5];
        exp[0] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000};
        exp[1] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
        exp[2] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001};
        exp[3] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000};
        exp[4] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
        run_cmd(2'd2, 0, 0);
        run_cmd(2'd2, 0, 1);
        cmd_op = 2'd3; cmd_src = 2'($urandom); cmd_dst = 2'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = 2'd0; cmd_src = 2'd0; cmd_dst = 2'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_total++;
            if (obs !== exp[k]) $display("FAIL back_to_back cycle t0+%0d: got %b expected %b", k + 1, obs, exp[k]);
            else n_pass++;
            if (k == 1) begin
                @(posedge clk); #1;
                cmd_valid = 1'b0;
            end
        end
        n_total++;
        if (bank4[1] !== 1'b1) $display("FAIL back_to_back r1: got %b expected 1", bank4[1]);
        else n_pass++;
        mem[0][0] = 1'b1;
        mem[0][1] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_out_of_range();
        sel3 = 1'b1;
        run_cmd(2'd3, 1, 0);
        run_cmd(2'd0, 3, 0);
        n_total++;
        if (bank3[0] !== 1'b0) $display("FAIL oor_mov r0: got %b expected 0", bank3[0]);
        else n_pass++;
        run_cmd(2'd3, 0, 1);
        run_cmd(2'd1, 1, 3);
        run_cmd(2'd2, 0, 2);
        sel3 = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [12:0] idle_vec;
        idle_vec = {1'b1, 12'b0};
        run_cmd(2'd3, 0, 0);
        run_cmd(2'd2, 0, 2);
        cmd_op = 2'd1; cmd_src = 2'd0; cmd_dst = 2'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (obs !== {1'b0, 1'b1, 3'b000, 4'b0000, 4'b0100})
            $display("FAIL mid_reset in RD_B: got %b expected %b", obs, {1'b0, 1'b1, 3'b000, 4'b0000, 4'b0100});
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (obs[11:0] !== 12'b0) $display("FAIL mid_reset async clear: got %b expected 0", obs[11:0]);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_total++;
            if (obs !== idle_vec) $display("FAIL mid_reset after release cycle %0d: got %b expected %b", k, obs, idle_vec);
            else n_pass++;
        end
        n_total++;
        if (bank4[2] !== 1'b0 || obs_bank !== model_bank(0, 4))
            $display("FAIL mid_reset bank: got %b expected %b", obs_bank, model_bank(0, 4));
        else n_pass++;
        @(posedge clk); #1;
        run_cmd(2'd1, 0, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clear_readback();
        test_set_mov();
        test_xor();
        test_back_to_back();
        test_random();
        test_out_of_range();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
